// File: rtl/ul_wr_ram_control.sv
// Write-side controller for the uplink ping-pong frame RAM: fills bank 0 / bank 1 alternately.
// Optional saturating drop counter on port dropCount when UL_WR_DROP_CNT_EN is defined.
module ul_wr_ram_control #(
    parameter int         DATA_W    = 8,
    parameter int         FRAME_LEN = 262,
    parameter logic [9:0] RAM0_BASE = 10'd0,
    parameter logic [9:0] RAM1_BASE = 10'd512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              UlDataRevEnable,
    input  logic [DATA_W-1:0] wrDataIn,
    input  logic              wrDataValid,
    input  logic              frameStart,
    input  logic [1:0]        UlRAM_rd_state,
    output logic [1:0]        UlRAM_wr_state,
    output logic              wrRAMEn,
    output logic [9:0]        wrRAMAddr,
    output logic [DATA_W-1:0] wrRAMData,
    output logic              frameDrop
`ifdef UL_WR_DROP_CNT_EN
    ,output logic [7:0]       dropCount
`endif
);

    localparam int             OFF_W    = $clog2(FRAME_LEN);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        WAIT_SOF,
        WRITE,
        COMMIT,
        DROP
    } state_t;

    state_t             state, state_n;
    logic               bank, bank_n;
    logic [OFF_W-1:0]   offset, offset_n;
    logic [1:0]         wr_state_n;
    logic               en_n, drop_n;
    logic [9:0]         addr_n;
    logic [DATA_W-1:0]  data_n;
    logic               sof_bank;

    function automatic logic [9:0] base_of(input logic b);
        return b ? RAM1_BASE : RAM0_BASE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= WAIT_SOF;
            bank           <= 1'b0;
            offset         <= '0;
            UlRAM_wr_state <= '0;
            wrRAMEn        <= 1'b0;
            wrRAMAddr      <= '0;
            wrRAMData      <= '0;
            frameDrop      <= 1'b0;
        end else begin
            state          <= state_n;
            bank           <= bank_n;
            offset         <= offset_n;
            UlRAM_wr_state <= wr_state_n;
            wrRAMEn        <= en_n;
            wrRAMAddr      <= addr_n;
            wrRAMData      <= data_n;
            frameDrop      <= drop_n;
        end
    end

    always_comb begin
        state_n    = state;
        bank_n     = bank;
        offset_n   = offset;
        // A bank is released only while it is marked full; stale read flags are harmless.
        wr_state_n = UlRAM_wr_state & ~UlRAM_rd_state;
        en_n       = 1'b0;
        addr_n     = wrRAMAddr;
        data_n     = wrRAMData;
        drop_n     = 1'b0;
        sof_bank   = (state == COMMIT) ? ~bank : bank;

        if (!UlDataRevEnable) begin
            state_n    = WAIT_SOF;
            wr_state_n = '0;
            bank_n     = 1'b0;
            offset_n   = '0;
        end else begin
            unique case (state)
                WRITE: begin
                    if (wrDataValid) begin
                        en_n   = 1'b1;
                        data_n = wrDataIn;
                        if (frameStart) begin
                            drop_n   = 1'b1;
                            addr_n   = base_of(bank);
                            offset_n = OFF_W'(1);
                        end else begin
                            addr_n   = base_of(bank) + 10'(offset);
                            offset_n = offset + 1'b1;
                            if (offset == LAST_OFF)
                                state_n = COMMIT;
                        end
                    end
                end
                default: begin
                    // COMMIT publishes the full bank and is simultaneously an SOF-wait
                    // against the toggled bank.
                    if (state == COMMIT) begin
                        wr_state_n[bank] = 1'b1;
                        bank_n           = ~bank;
                        offset_n         = '0;
                        state_n          = WAIT_SOF;
                    end
                    if (wrDataValid && frameStart) begin
                        bank_n = sof_bank;
                        if (!UlRAM_wr_state[sof_bank]) begin
                            en_n     = 1'b1;
                            addr_n   = base_of(sof_bank);
                            data_n   = wrDataIn;
                            offset_n = OFF_W'(1);
                            state_n  = WRITE;
                        end else begin
                            drop_n  = 1'b1;
                            state_n = DROP;
                        end
                    end
                end
            endcase
        end
    end

`ifdef UL_WR_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dropCount <= '0;
        else if (!UlDataRevEnable)
            dropCount <= '0;
        else if (drop_n && dropCount != 8'hFF)
            dropCount <= dropCount + 8'd1;
    end
`endif

endmodule
